vedic_seq_mult_ctrl: RTL and testbench

Sequencing controller that time-multiplexes a single 2-bit Vedic multiplier cell (`vedicmult_2bit`) to form a full WIDTH x WIDTH unsigned product. Each operand is split into 2-bit digits. The controller steps through every digit pair, one per clock, and accumulates each shifted partial product into a 2*WIDTH accumulator. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It is the area-minimal alternative to a fully unrolled Vedic tree.

---
 rtl/vedic_seq_mult_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_vedic_seq_mult_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/vedic_seq_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vedic_seq_mult_ctrl (with leaf cell vedicmult_2bit)
// Purpose  : Sequential WIDTH x WIDTH unsigned multiplier. A single 2-bit
//            Vedic multiplier cell is time-multiplexed over every pair of
//            2-bit operand digits, one pair per clock. Each shifted partial
//            product is accumulated into a 2*WIDTH register.
// Ports    : clk, rst (async, active-high)
//            in_valid_i / in_ready_o   - operand handshake (a_i, b_i)
//            out_valid_o / out_ready_i - result handshake (product_o)
//            busy_o                    - high while digit pairs are stepped
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// vedicmult_2bit: 2x2 unsigned multiply using the Urdhva-Tiryagbhyam pattern
// (vertical and crosswise products), built only from AND/XOR terms.
// ----------------------------------------------------------------------------
module vedicmult_2bit (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic [3:0] p_o
);
    logic vert_lo;   // a0*b0
    logic cross_0;   // a1*b0
    logic cross_1;   // a0*b1
    logic vert_hi;   // a1*b1
    logic carry_1;   // carry out of the crosswise column

    assign vert_lo = a_i[0] & b_i[0];
    assign cross_0 = a_i[1] & b_i[0];
    assign cross_1 = a_i[0] & b_i[1];
    assign vert_hi = a_i[1] & b_i[1];
    assign carry_1 = cross_0 & cross_1;

    assign p_o[0] = vert_lo;
    assign p_o[1] = cross_0 ^ cross_1;
    assign p_o[2] = vert_hi ^ carry_1;
    assign p_o[3] = vert_hi & carry_1;
endmodule

// ----------------------------------------------------------------------------
// vedic_seq_mult_ctrl: top-level sequencing controller
// ----------------------------------------------------------------------------
module vedic_seq_mult_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [2*WIDTH-1:0] product_o,
    output logic               busy_o
);
    localparam int N   = WIDTH / 2;                     // digits per operand
    localparam int IW  = (N > 1) ? $clog2(N) : 1;       // digit index width
    localparam int PW  = 2 * WIDTH;                     // product width
    localparam int SHW = IW + 2;                        // shift amount width

    localparam logic [IW-1:0] LAST_DIG = IW'(N - 1);
    localparam logic [IW-1:0] ONE_DIG  = IW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [IW-1:0]     i_q, i_d;
    logic [IW-1:0]     j_q, j_d;

    // ------------------------------------------------------------------
    // Datapath: digit select, single multiplier cell, shifted addend
    // ------------------------------------------------------------------
    logic [1:0]     a_dig;
    logic [1:0]     b_dig;
    logic [3:0]     pp;
    logic [PW-1:0]  pp_ext;
    logic [SHW-1:0] shamt;
    logic [PW-1:0]  addend;

    // Digit k occupies bits [2k+1:2k]; {k,1'b0} is 2k.
    assign a_dig = a_q[{i_q, 1'b0} +: 2];
    assign b_dig = b_q[{j_q, 1'b0} +: 2];

    vedicmult_2bit u_cell (
        .a_i (a_dig),
        .b_i (b_dig),
        .p_o (pp)
    );

    // Zero-extend via assignment so WIDTH=2 (PW=4) needs no zero-width pad.
    always_comb begin
        pp_ext      = '0;
        pp_ext[3:0] = pp;
    end

    // Digit pair (i,j) carries weight 4^(i+j), i.e. a left shift of 2*(i+j).
    // Largest shift is 2W-4, so the 4-bit partial product always fits.
    assign shamt  = {(SHW-1)'(i_q) + (SHW-1)'(j_q), 1'b0};
    assign addend = pp_ext << shamt;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        i_d     = i_q;
        j_d     = j_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    a_d   = a_i;
                    b_d   = b_i;
                    acc_d = '0;
                    i_d   = '0;
                    j_d   = '0;
                    // A zero operand makes the product trivially zero, so the
                    // digit loop is skipped entirely.
                    if ((a_i == '0) || (b_i == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end

            S_RUN: begin
                acc_d = acc_q + addend;
                if (j_q == LAST_DIG) begin
                    j_d = '0;
                    if (i_q == LAST_DIG) begin
                        // Final digit pair is accumulated on this same edge.
                        state_d = S_DONE;
                    end else begin
                        i_d = i_q + ONE_DIG;
                    end
                end else begin
                    j_d = j_q + ONE_DIG;
                end
            end

            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state only, so neither handshake
    // input has a combinational path to any output.
    // ------------------------------------------------------------------
    assign in_ready_o  = (state_q == S_IDLE);
    assign busy_o      = (state_q == S_RUN);
    assign out_valid_o = (state_q == S_DONE);
    assign product_o   = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_vedic_seq_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vedic_seq_mult_ctrl
// Purpose  : Self-checking bench for vedic_seq_mult_ctrl (WIDTH=8). Expected
//            products are computed from the driven operands and queued; each
//            completed result is compared against the head of the queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vedic_seq_mult_ctrl;
    localparam int W = 8;
    localparam int S = (W / 2) * (W / 2);

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;
    logic           busy;

    int n_assert;
    int n_fail;
    int cyc;

    logic [2*W-1:0] sb[$];

    vedic_seq_mult_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .product_o   (product),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer operands, wait (bounded) for the accept edge, return its cycle.
    task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv, output int acc_cyc);
        int guard;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("accept_timeout", 32'(guard < 50), 32'd1);
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        sb.push_back((2*W)'(av) * (2*W)'(bv));
    endtask

    // One full transaction, optionally with 5 cycles of result backpressure.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input bit backpressure, output int acc_cyc);
        int             n;
        int             exp_lat;
        logic           exp_busy;
        logic [2*W-1:0] exp_p;
        bit             zero;
        zero     = (av == '0) || (bv == '0);
        exp_lat  = zero ? 0 : S;
        exp_busy = zero ? 1'b0 : 1'b1;
        out_ready = backpressure ? 1'b0 : 1'b1;
        accept(av, bv, acc_cyc);
        n = 0;
        while (!out_valid && n < 40) begin
            check("busy_during_run", 32'(busy), 32'(exp_busy));
            @(posedge clk); #1;
            n++;
        end
        exp_p = (sb.size() > 0) ? sb.pop_front() : '1;
        check("latency", 32'(n), 32'(exp_lat));
        check("out_valid", 32'(out_valid), 32'd1);
        check("busy_in_done", 32'(busy), 32'd0);
        check("product", 32'(product), 32'(exp_p));
        if (backpressure) begin
            in_valid = 1'b1;
            a        = 8'h11;
            b        = 8'h22;
            repeat (5) begin
                @(posedge clk); #1;
                check("bp_out_valid", 32'(out_valid), 32'd1);
                check("bp_in_ready", 32'(in_ready), 32'd0);
                check("bp_product", 32'(product), 32'(exp_p));
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            // in_valid was still high on the handshake edge: must not accept.
            check("bp_release_in_ready", 32'(in_ready), 32'd1);
            check("bp_release_busy", 32'(busy), 32'd0);
            check("bp_release_out_valid", 32'(out_valid), 32'd0);
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            check("handshake_out_valid", 32'(out_valid), 32'd0);
            check("handshake_in_ready", 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        int c0, c1, c2, c3;
        n_assert  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;

        // Reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_product", 32'(product), 32'h0000);

        // Full-scale product
        run_op(8'hFF, 8'hFF, 1'b0, c0);

        // Small operands, back-to-back
        run_op(8'h03, 8'h03, 1'b0, c1);
        run_op(8'h02, 8'h03, 1'b0, c2);
        check("spacing_1", 32'(c2 - c1), 32'(S + 2));
        run_op(8'h01, 8'h01, 1'b0, c3);
        check("spacing_2", 32'(c3 - c2), 32'(S + 2));

        // Zero bypass, both operand positions
        run_op(8'h00, 8'hA5, 1'b0, c0);
        run_op(8'h5A, 8'h00, 1'b0, c0);

        // Backpressure with in_valid held high
        run_op(8'hC8, 8'h7B, 1'b1, c0);

        // Asynchronous reset mid-operation at step 7
        accept(8'hFF, 8'h11, c0);
        repeat (7) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_product", 32'(product), 32'h0000);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run_op(8'h0F, 8'h0F, 1'b0, c0);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
